// File: rtl/sd_sector_arbiter.sv
// Two-requester arbiter for the hps_io SD sector channel (HEX loader = 0, save/EEPROM path = 1).
// Define SD_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module sd_sector_arbiter #(
  parameter int TIMEOUT_W = 24
) (
  input  logic       clk_100m,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       req0_wr,
  input  logic       req1_wr,
  input  logic [8:0] req0_lba,
  input  logic [8:0] req1_lba,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       err,
  output logic       owner,
  output logic       busy,
  output logic [8:0] sd_lba,
  output logic       sd_rd,
  output logic       sd_wr,
  input  logic       sd_ack
);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

  localparam logic [TIMEOUT_W-1:0] WDOG_ONE = 1;

  state_t               state;
  logic [TIMEOUT_W-1:0] wdog;
  logic [TIMEOUT_W-1:0] wdog_inc;
  logic                 pick1;
  logic                 pick_wr;
  logic [8:0]           pick_lba;

`ifdef SD_ARB_RR_EN
  // Index of the requester served most recently; reset to 1 so req0 wins the first tie.
  logic last;

  always_ff @(posedge clk_100m) begin
    if (reset)
      last <= 1'b1;
    else if (state == IDLE && (req0 || req1))
      last <= pick1;
  end

  assign pick1 = req1 & (~req0 | ~last);
`else
  assign pick1 = req1 & ~req0;
`endif

  assign pick_wr  = pick1 ? req1_wr  : req0_wr;
  assign pick_lba = pick1 ? req1_lba : req0_lba;
  assign wdog_inc = wdog + WDOG_ONE;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk_100m) begin
    if (reset) begin
      state  <= IDLE;
      wdog   <= '0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      err    <= 1'b0;
      owner  <= 1'b0;
      sd_lba <= '0;
      sd_rd  <= 1'b0;
      sd_wr  <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state  <= ISSUE;
            owner  <= pick1;
            sd_lba <= pick_lba;
            gnt0   <= ~pick1;
            gnt1   <= pick1;
            sd_wr  <= pick_wr;
            sd_rd  <= ~pick_wr;
            wdog   <= '0;
          end
        end
        ISSUE: begin
          if (sd_ack) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            wdog  <= '0;
            state <= XFER;
          end else if (&wdog_inc) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            wdog  <= wdog_inc;
            err   <= 1'b1;
            done0 <= gnt0;
            done1 <= gnt1;
            state <= DONE;
          end else begin
            wdog <= wdog_inc;
          end
        end
        XFER: begin
          if (!sd_ack) begin
            done0 <= gnt0;
            done1 <= gnt1;
            state <= DONE;
          end else if (&wdog_inc) begin
            wdog  <= wdog_inc;
            err   <= 1'b1;
            done0 <= gnt0;
            done1 <= gnt1;
            state <= DONE;
          end else begin
            wdog <= wdog_inc;
          end
        end
        DONE: begin
          // Grant is held through DONE and dropped on the way back to IDLE; owner is kept.
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Randomized bench for sd_sector_arbiter: the bench plays both requesters and hps_io and
// predicts every cycle from transaction-level rules (winner choice, handshake latencies).
module tb_sd_sector_arbiter;

  localparam int TW  = 4;
  localparam int TMO = (1 << TW) - 1;

  logic       clk_100m = 1'b0;
  logic       reset    = 1'b1;
  logic       req0     = 1'b0;
  logic       req1     = 1'b0;
  logic       req0_wr  = 1'b0;
  logic       req1_wr  = 1'b0;
  logic [8:0] req0_lba = '0;
  logic [8:0] req1_lba = '0;
  logic       sd_ack   = 1'b0;
  logic       gnt0, gnt1, done0, done1, err, owner, busy, sd_rd, sd_wr;
  logic [8:0] sd_lba;

  int vectors     = 0;
  int miscompares = 0;
  bit last_m      = 1'b1;
  int order [4];

  sd_sector_arbiter #(.TIMEOUT_W(TW)) dut (
    .clk_100m (clk_100m),
    .reset    (reset),
    .req0     (req0),
    .req1     (req1),
    .req0_wr  (req0_wr),
    .req1_wr  (req1_wr),
    .req0_lba (req0_lba),
    .req1_lba (req1_lba),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .done0    (done0),
    .done1    (done1),
    .err      (err),
    .owner    (owner),
    .busy     (busy),
    .sd_lba   (sd_lba),
    .sd_rd    (sd_rd),
    .sd_wr    (sd_wr),
    .sd_ack   (sd_ack)
  );

  always #5 clk_100m = ~clk_100m;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // g = granted requester index, or -1 for no grant.
  task automatic chk_outs(input string tag, input int g, input bit dn, input bit er,
                          input bit bz, input bit rd, input bit wr);
    logic [7:0] got, exp;
    got = {gnt0, gnt1, done0, done1, err, busy, sd_rd, sd_wr};
    exp = {g == 0, g == 1, dn && g == 0, dn && g == 1, er, bz, rd, wr};
    check_val(tag, 32'(got), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk_100m);
    #1;
  endtask

  function automatic int pick_model(input bit p0, input bit p1);
    if (p0 && p1) begin
`ifdef SD_ARB_RR_EN
      return last_m ? 0 : 1;
`else
      return 0;
`endif
    end
    return p0 ? 0 : 1;
  endfunction

  task automatic drop_req(input int w);
    if (w == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  // mode 0: normal handshake, 1: no ack (ISSUE timeout), 2: ack stuck high (XFER timeout).
  task automatic run_txn(input int mode, input int d, input int h, input bit drop);
    int         w;
    bit         wr;
    logic [8:0] lba;
    w   = pick_model(req0, req1);
    wr  = (w == 0) ? req0_wr : req1_wr;
    lba = (w == 0) ? req0_lba : req1_lba;
    tick();
    last_m = (w == 1);
    chk_outs("grant", w, 1'b0, 1'b0, 1'b1, !wr, wr);
    check_val("grant_lba", 32'(sd_lba), 32'(lba));
    check_val("grant_owner", 32'(owner), 32'(w));
    if (mode == 1) begin
      for (int k = 1; k < TMO; k++) begin
        tick();
        chk_outs("issue_hold", w, 1'b0, 1'b0, 1'b1, !wr, wr);
      end
      tick();
      chk_outs("issue_timeout", w, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    end else begin
      for (int k = 0; k < d; k++) begin
        tick();
        chk_outs("issue_wait", w, 1'b0, 1'b0, 1'b1, !wr, wr);
      end
      sd_ack = 1'b1;
      tick();
      chk_outs("ack_release", w, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (drop) drop_req(w);
      if (mode == 2) begin
        for (int k = 1; k < TMO; k++) begin
          tick();
          chk_outs("xfer_hold", w, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        tick();
        chk_outs("xfer_timeout", w, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        sd_ack = 1'b0;
      end else begin
        for (int k = 1; k < h; k++) begin
          tick();
          chk_outs("xfer_hold", w, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        sd_ack = 1'b0;
        tick();
        chk_outs("done", w, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      end
    end
    check_val("done_lba", 32'(sd_lba), 32'(lba));
    check_val("done_owner", 32'(owner), 32'(w));
    tick();
    drop_req(w);
    chk_outs("back_to_idle", -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("idle_owner", 32'(owner), 32'(w));
  endtask

  initial begin
    int mode;

    // Reset state
    repeat (2) tick();
    chk_outs("reset", -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("reset_lba", 32'(sd_lba), 32'd0);
    check_val("reset_owner", 32'(owner), 32'd0);
    reset = 1'b0;
    sd_ack = 1'b1;
    tick();
    chk_outs("idle_ack_ignored", -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sd_ack = 1'b0;

    // Single read from requester 1
    req1 = 1'b1; req1_wr = 1'b0; req1_lba = 9'h005;
    run_txn(0, 4, 3, 1'b0);

    // Single write from requester 0
    req0 = 1'b1; req0_wr = 1'b1; req0_lba = 9'h1FF;
    run_txn(0, 2, 2, 1'b0);

    // Watchdog in both waiting phases
    req0 = 1'b1; req0_wr = 1'b0; req0_lba = 9'h0A5;
    run_txn(1, 0, 1, 1'b0);
    req1 = 1'b1; req1_wr = 1'b1; req1_lba = 9'h13C;
    run_txn(2, 1, 1, 1'b0);

    // Reset while in XFER with sd_ack high
    req1 = 1'b1; req1_wr = 1'b0; req1_lba = 9'h0F3;
    tick();
    chk_outs("rst_grant", 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    sd_ack = 1'b1;
    tick();
    chk_outs("rst_xfer", 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    req1  = 1'b0;
    tick();
    reset = 1'b0;
    last_m = 1'b1;
    chk_outs("rst_abandon", -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("rst_abandon_lba", 32'(sd_lba), 32'd0);
    check_val("rst_abandon_owner", 32'(owner), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk_outs("rst_ack_ignored", -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    sd_ack = 1'b0;

    // Simultaneous requests held by both sides
`ifdef SD_ARB_RR_EN
    order = '{0, 1, 0, 1};
`else
    order = '{0, 0, 0, 1};
`endif
    req0_lba = 9'h011; req1_lba = 9'h122; req0_wr = 1'b0; req1_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0 = (i < 3);
      req1 = 1'b1;
      run_txn(0, 1, 1, 1'b0);
      check_val("tie_order", 32'(owner), 32'(order[i]));
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // Randomized traffic
    for (int it = 0; it < 160; it++) begin
      if (!req0 && $urandom_range(0, 1) == 1) begin
        req0 = 1'b1; req0_wr = 1'($urandom_range(0, 1)); req0_lba = 9'($urandom);
      end
      if (!req1 && $urandom_range(0, 1) == 1) begin
        req1 = 1'b1; req1_wr = 1'($urandom_range(0, 1)); req1_lba = 9'($urandom);
      end
      if (!req0 && !req1) begin
        sd_ack = 1'($urandom_range(0, 1));
        tick();
        chk_outs("idle_noise", -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sd_ack = 1'b0;
        continue;
      end
      mode = $urandom_range(0, 9);
      mode = (mode < 8) ? 0 : mode - 7;
      run_txn(mode, $urandom_range(0, 8), $urandom_range(1, 4), $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
